// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: PC/instruction words, fetch FSM states and the
// buffered {pc, insn} entry.
package fetch_unit_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] insn_t;

    localparam pc_t PcStep = 32'd4;

    typedef enum logic [1:0] {
        FIdle = 2'b00,
        FWait = 2'b01,
        FKill = 2'b10
    } fetch_state_e;

    typedef struct packed {
        pc_t   pc;
        insn_t insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_insn_fifo.sv
// Synchronous FIFO of fetched {pc, insn} entries with a single-cycle flush.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_unit_insn_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned CntW  = AddrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    output fetch_entry_t    head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] occupancy_o
);

    fetch_entry_t     mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o      = (count_q == CntW'(Depth));
    assign empty_o     = (count_q == '0);
    assign occupancy_o = count_q;
    assign head_o      = mem_q[rd_ptr_q];
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack, {pc, insn} buffer, redirect squash.
// Define FETCH_STALL_CNT_EN to add the stall_cycles and kill_count counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    input  logic        insn_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] kill_count
`endif
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q;
    pc_t             fetch_pc_q;
    pc_t             req_addr_q;

    logic            issue;
    logic            in_flight;
    logic            take_data;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] occupancy;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_push_data;

    // Credit check uses registered occupancy only, so a pop frees its slot one cycle later.
    assign issue     = (state_q == FIdle) && (occupancy < CntW'(FIFO_DEPTH)) &&
                       !redirect_valid && !rst;
    assign in_flight = (state_q != FIdle) && !rst;
    assign imem_req  = issue || in_flight;

    always_comb begin
        imem_addr = '0;
        if (issue) begin
            imem_addr = fetch_pc_q;
        end else if (in_flight) begin
            imem_addr = req_addr_q;
        end
    end

    assign take_data      = imem_ack && !redirect_valid && (issue || (in_flight && state_q == FWait));
    assign fifo_push_data = '{pc: fetch_pc_q, insn: imem_rdata};
    assign insn_valid     = !fifo_empty && !rst;
    assign fifo_pop       = insn_valid && insn_ready;
    assign insn           = insn_valid ? fifo_head.insn : '0;
    assign insn_pc        = insn_valid ? fifo_head.pc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            case (state_q)
                FIdle: begin
                    if (issue && !imem_ack) begin
                        state_q    <= FWait;
                        req_addr_q <= fetch_pc_q;
                    end
                end
                FWait: begin
                    if (imem_ack) begin
                        state_q <= FIdle;
                    end else if (redirect_valid) begin
                        state_q <= FKill;
                    end
                end
                FKill: begin
                    if (imem_ack) begin
                        state_q <= FIdle;
                    end
                end
                default: state_q <= FIdle;
            endcase

            if (redirect_valid) begin
                fetch_pc_q <= redirect_target;
            end else if (take_data) begin
                fetch_pc_q <= fetch_pc_q + PcStep;
            end
        end
    end

    fetch_unit_insn_fifo #(
        .Depth(FIFO_DEPTH)
    ) u_insn_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (redirect_valid),
        .push_i      (take_data),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .occupancy_o (occupancy)
    );

    // One outstanding request is only issued into a free slot, so a push never meets a full buffer.
    assert property (@(posedge clk) disable iff (rst) !(take_data && fifo_full && !fifo_pop));

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] kill_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            kill_count_q   <= '0;
        end else begin
            if (insn_valid && !insn_ready && stall_cycles_q != '1) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (state_q == FKill && imem_ack) begin
                kill_count_q <= kill_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign kill_count   = kill_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference vector table, directed redirect/reset/wrap
// sequences, and randomized traffic checked against an instruction-stream model.
module tb_fetch_unit;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Main instance: RESET_PC = 0, depth 2.
    logic        imem_req, imem_ack, redirect_valid, insn_valid, insn_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_target, insn, insn_pc;
    // Second instance: RESET_PC at the top of the address space, depth 4.
    logic        w_req, w_ack, w_redir, w_valid, w_ready;
    logic [31:0] w_addr, w_rdata, w_target, w_insn, w_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cycles, w_stall;
    logic [15:0] kill_count, w_kill;
`endif

    int unsigned lat, cnt, w_lat, w_cnt;
    int          n_err, n_chk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory models: ack once the request has been held for at least 'lat' cycles.
    assign imem_ack   = imem_req && (cnt >= lat);
    assign imem_rdata = mem_word(imem_addr);
    assign w_ack      = w_req && (w_cnt >= w_lat);
    assign w_rdata    = mem_word(w_addr);

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
        if (rst || !w_req || w_ack) w_cnt <= 0;
        else w_cnt <= w_cnt + 1;
    end

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .insn            (insn),
        .insn_pc         (insn_pc),
        .insn_valid      (insn_valid),
        .insn_ready      (insn_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .kill_count      (kill_count)
`endif
    );

    fetch_unit #(
        .RESET_PC   (32'hFFFF_FFFC),
        .FIFO_DEPTH (4)
    ) u_wrap (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (w_req),
        .imem_addr       (w_addr),
        .imem_ack        (w_ack),
        .imem_rdata      (w_rdata),
        .redirect_valid  (w_redir),
        .redirect_target (w_target),
        .insn            (w_insn),
        .insn_pc         (w_pc),
        .insn_valid      (w_valid),
        .insn_ready      (w_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles    (w_stall),
        .kill_count      (w_kill)
`endif
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves the bench at the start of the first cycle after reset release.
    task automatic do_reset();
        cyc();
        rst = 1'b1;
        redirect_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] target;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                                input logic [31:0] tgt, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.ready = rdy; v.redir = rv; v.target = tgt;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        logic        found, got_ack, bad, p_req, p_ack, p_redir, p_rst;
        logic [31:0] p_addr, exp_pc;
        int          acks, pops, stall_model;

        n_err = 0; n_chk = 0;
        rst = 1'b1; lat = 0; w_lat = 0;
        redirect_valid = 1'b0; redirect_target = '0; insn_ready = 1'b0;
        w_redir = 1'b0; w_target = '0; w_ready = 1'b0;

        // Zero-wait memory: streaming, back-pressure with two acks then stop, drain, redirect.
        vecs[0]  = mk(T, F, F, 32'h0,  F, 32'h0,  F, 32'h0);
        vecs[1]  = mk(F, T, F, 32'h0,  T, 32'h0,  F, 32'h0);
        vecs[2]  = mk(F, T, F, 32'h0,  T, 32'h4,  T, 32'h0);
        vecs[3]  = mk(F, T, F, 32'h0,  T, 32'h8,  T, 32'h4);
        vecs[4]  = mk(F, T, F, 32'h0,  T, 32'hC,  T, 32'h8);
        vecs[5]  = mk(T, F, F, 32'h0,  F, 32'h0,  F, 32'h0);
        vecs[6]  = mk(F, F, F, 32'h0,  T, 32'h0,  F, 32'h0);
        vecs[7]  = mk(F, F, F, 32'h0,  T, 32'h4,  T, 32'h0);
        vecs[8]  = mk(F, F, F, 32'h0,  F, 32'h0,  T, 32'h0);
        vecs[9]  = mk(F, F, F, 32'h0,  F, 32'h0,  T, 32'h0);
        vecs[10] = mk(F, T, F, 32'h0,  F, 32'h0,  T, 32'h0);
        vecs[11] = mk(F, T, F, 32'h0,  T, 32'h8,  T, 32'h4);
        vecs[12] = mk(F, T, F, 32'h0,  T, 32'hC,  T, 32'h8);
        vecs[13] = mk(F, T, T, 32'h40, F, 32'h0,  T, 32'hC);
        vecs[14] = mk(F, T, F, 32'h0,  T, 32'h40, F, 32'h0);
        vecs[15] = mk(F, T, F, 32'h0,  T, 32'h44, T, 32'h40);

        cyc();
        cyc();
        for (int i = 0; i < 16; i++) begin
            cyc();
            rst = vecs[i].rst;
            insn_ready = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_target = vecs[i].target;
            smp();
            chk1($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
            chk32($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk1($sformatf("vec%0d_valid", i), insn_valid, vecs[i].exp_valid);
            chk32($sformatf("vec%0d_pc", i), insn_pc, vecs[i].exp_valid ? vecs[i].exp_pc : 32'h0);
            chk32($sformatf("vec%0d_insn", i), insn,
                  vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0);
        end
        redirect_valid = 1'b0;

        // 3-cycle memory, redirect to 0x100 one cycle after 0x8 is issued.
        do_reset();
        lat = 3; insn_ready = 1'b1;
        found = 1'b0; bad = 1'b0; got_ack = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            smp();
            if (imem_req && imem_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        chk1("lat3_issue8", found, 1'b1);
        cyc();
        redirect_valid = 1'b1; redirect_target = 32'h100;
        smp();
        chk1("lat3_redir_req", imem_req, 1'b1);
        chk32("lat3_redir_addr", imem_addr, 32'h8);
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc();
            smp();
            chk1("lat3_hold_req", imem_req, 1'b1);
            chk32("lat3_hold_addr", imem_addr, 32'h8);
            if (insn_valid) bad = 1'b1;
            if (imem_ack) begin
                got_ack = 1'b1;
                break;
            end
        end
        chk1("lat3_kill_ack", got_ack, 1'b1);
        cyc();
        smp();
        chk1("lat3_next_req", imem_req, 1'b1);
        chk32("lat3_next_addr", imem_addr, 32'h100);
`ifdef FETCH_STALL_CNT_EN
        chk32("lat3_kill_count", {16'h0, kill_count}, 32'h1);
`endif
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (insn_valid) begin
                found = 1'b1;
                break;
            end
            cyc();
            smp();
        end
        chk1("lat3_first_valid", found, 1'b1);
        chk1("lat3_no_stale", bad, 1'b0);
        chk32("lat3_first_pc", insn_pc, 32'h100);
        chk32("lat3_first_insn", insn, mem_word(32'h100));

        // Redirect to 0x40 in the same cycle as the 0x10 ack and a decoder pop.
        do_reset();
        lat = 1; insn_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            insn_ready = 1'b1;
            smp();
            if (imem_req && imem_addr == 32'h10 && !imem_ack) begin
                insn_ready = 1'b0;
                found = 1'b1;
                break;
            end
        end
        chk1("same_issue10", found, 1'b1);
        cyc();
        insn_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        smp();
        chk1("same_ack", imem_ack, 1'b1);
        chk32("same_ack_addr", imem_addr, 32'h10);
        chk1("same_pop_valid", insn_valid, 1'b1);
        chk32("same_pop_pc", insn_pc, 32'hC);
        cyc();
        redirect_valid = 1'b0;
        smp();
        chk1("same_empty", insn_valid, 1'b0);
        chk1("same_next_req", imem_req, 1'b1);
        chk32("same_next_addr", imem_addr, 32'h40);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            smp();
            if (insn_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk1("same_first_valid", found, 1'b1);
        chk32("same_first_pc", insn_pc, 32'h40);

        // Address wrap from 0xFFFF_FFFC.
        do_reset();
        w_lat = 0; w_ready = 1'b1;
        smp();
        chk1("wrap_req", w_req, 1'b1);
        chk32("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        chk1("wrap_valid0", w_valid, 1'b0);
        cyc();
        smp();
        chk32("wrap_addr1", w_addr, 32'h0);
        chk32("wrap_pc0", w_pc, 32'hFFFF_FFFC);
        chk32("wrap_insn0", w_insn, mem_word(32'hFFFF_FFFC));
        cyc();
        smp();
        chk32("wrap_addr2", w_addr, 32'h4);
        chk32("wrap_pc1", w_pc, 32'h0);
        chk32("wrap_insn1", w_insn, mem_word(32'h0));

        // Reset while a request is outstanding with two buffered entries.
        do_reset();
        w_lat = 3; w_ready = 1'b0;
        found = 1'b0; acks = 0; stall_model = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) cyc();
            smp();
            if (w_valid && !w_ready) stall_model++;
            if (w_req && !w_ack && acks == 2) begin
                found = 1'b1;
                break;
            end
            if (w_req && w_ack) acks++;
        end
        chk1("rst_third_issue", found, 1'b1);
        cyc();
        smp();
        chk1("rst_pre_req", w_req, 1'b1);
        chk1("rst_pre_valid", w_valid, 1'b1);
`ifdef FETCH_STALL_CNT_EN
        chk32("rst_pre_stall", w_stall, 32'(stall_model));
`endif
        cyc();
        rst = 1'b1;
        smp();
        chk1("rst_valid", w_valid, 1'b0);
        chk1("rst_req", w_req, 1'b0);
        cyc();
        rst = 1'b0;
        smp();
        chk1("rst_after_req", w_req, 1'b1);
        chk32("rst_after_addr", w_addr, 32'hFFFF_FFFC);
        chk1("rst_after_valid", w_valid, 1'b0);
`ifdef FETCH_STALL_CNT_EN
        chk32("rst_after_stall", w_stall, 32'h0);
`endif

        // Random traffic: the decoder must see a contiguous +4 stream restarting at each target.
        do_reset();
        w_ready = 1'b0;
        exp_pc = 32'h0; pops = 0;
        p_req = 1'b0; p_ack = 1'b0; p_redir = 1'b0; p_rst = 1'b1; p_addr = '0;
        for (int i = 0; i < 600; i++) begin
            if (i > 0) cyc();
            insn_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom;
            lat = $urandom_range(0, 3);
            smp();
            if (p_redir) chk1("rand_valid_after_redir", insn_valid, 1'b0);
            if (p_req && !p_ack && !p_rst) begin
                chk1("rand_req_held", imem_req, 1'b1);
                chk32("rand_addr_stable", imem_addr, p_addr);
            end
            if (insn_valid && insn_ready && !redirect_valid) begin
                chk32("rand_pc", insn_pc, exp_pc);
                chk32("rand_insn", insn, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redirect_valid) exp_pc = redirect_target;
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            p_redir = redirect_valid; p_rst = rst;
        end
        chk1("rand_progress", pops > 20, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack interface, one request outstanding at a time.
- Buffers returned instructions in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Accepts branch redirects from the branch-resolution logic and squashes stale work.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address; stable while imem_req is high.
- imem_ack  in  1  memory has returned imem_rdata; may assert in the same cycle as imem_req (zero wait) or later.
- imem_rdata  in  32  `instruction word; valid only when imem_ack is high.
- redirect_valid  in  1  branch taken: discard all fetched or in-flight instructions.
- redirect_target  in  32  new PC when redirect_valid is high.
- insn  out  32  `instruction to the decoder (FIFO head).
- insn_pc  out  32  PC of insn.
- insn_valid  out  1  FIFO non-empty.
- insn_ready  in  1  decoder consumes insn when insn_valid && insn_ready.

Behaviour:
- Reset (rst high at an edge):
  - fetch_pc = RESET_PC; FIFO empty; state IDLE.
  - imem_req = 0, insn_valid = 0; imem_addr, insn and insn_pc = 0.
  - Reset mid-request abandons the in-flight transaction; memory must also be reset.
- State machine:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its data will be kept.
  - KILL: request outstanding; its data will be dropped.
- Issue rule: in IDLE, imem_req = 1 and imem_addr = fetch_pc when (occupancy + 0) < FIFO_DEPTH and redirect_valid = 0. The state becomes WAIT at that edge unless imem_ack is high the same cycle.
- Credits:
  - A pop in the current cycle frees a credit only from the next cycle.
  - Occupancy never exceeds FIFO_DEPTH.
- Ack in WAIT, or a zero-wait ack in IDLE:
  - Push {imem_rdata, fetch_pc}.
  - fetch_pc += 4, wrapping modulo 2^32.
  - Next state is IDLE.
- Ack in KILL: data dropped; next state is IDLE.
- Redirect (redirect_valid = 1):
  - FIFO flushed; fetch_pc = redirect_target.
  - WAIT goes to KILL. An ack arriving in the same cycle as the redirect is dropped and the state goes to IDLE.
  - imem_req stays high in WAIT/KILL until ack; a request is never withdrawn.
  - Redirect beats a simultaneous pop and push.
  - insn_valid = 0 in the cycle after a redirect.
- Throughput:
  - With zero-wait memory and insn_ready = 1, one instruction per cycle.
  - Latency from request to insn_valid is ack cycle + 1.
- Pop and push in the same cycle are both honoured; occupancy is unchanged.
- redirect_target bits [1:0] are used as given; no alignment check.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- When defined: adds output stall_cycles (32 bits, reset 0), which increments, saturating, every cycle insn_valid && !insn_ready, and separately exports kill_count (16 bits, reset 0), which increments on every KILL-state ack.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Types.v additions:
  - `pc macro (32-bit vector).
  - Fetch state encodings `F_IDLE / `F_WAIT / `F_KILL.
  - `PC_STEP constant (4).
- Reuse the existing `instruction, `TRUE and `FALSE macros.
- One natural sub-module, insn_fifo: parameterized synchronous FIFO carrying {pc, insn}, with push, pop, flush, full, empty and occupancy ports. fetch_unit instantiates it.

Test Plan:
- Reset release, zero-wait memory, insn_ready = 1:
  - imem_req = 1 with imem_addr = 0x0 on the first cycle.
  - insn_pc on consecutive cycles is 0x0, 0x4, 0x8, …, with insn matching memory.
- insn_ready held 0, zero-wait memory:
  - Exactly 2 acks, then imem_req = 0.
  - Raising insn_ready drains 0x0 then 0x4, and fetch resumes at 0x8.
- 3-cycle memory latency, redirect to 0x100 one cycle after issuing 0x8:
  - imem_req stays high until the ack; the 0x8 data is never seen at insn.
  - The next request is to 0x100, and the first valid insn_pc is 0x100.
- Redirect to 0x40 in the same cycle as the ack for 0x10 and a decoder pop:
  - The FIFO is empty next cycle; the 0x10 instruction is dropped.
  - The next request is to 0x40.
- Address wrap: RESET_PC = 0xFFFF_FFFC.
  - Fetch sequence is 0xFFFF_FFFC then 0x0000_0000.
- rst asserted while in WAIT with 2 buffered entries:
  - The next cycle shows insn_valid = 0 and imem_req = 0; the following cycle requests RESET_PC.
  - With FETCH_STALL_CNT_EN, stall_cycles returns to 0.
